// File: rtl/ringosc_meas_ctrl.sv
// Ring-oscillator measurement controller: enable ring, settle, count synchronised
// osc edges over a programmable window, report a saturating count.
module ringosc_meas_ctrl #(
    parameter int unsigned WINDOW_W   = 16,
    parameter int unsigned COUNT_W    = 16,
    parameter int unsigned SETTLE_CYC = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    input  logic                abort_i,
    input  logic [WINDOW_W-1:0] window_i,
    input  logic                osc_i,
    output logic                osc_en_o,
    output logic                busy_o,
    output logic                done_o,
    output logic [COUNT_W-1:0]  result_o,
    output logic                overflow_o
);

    localparam int unsigned SetW = $clog2(SETTLE_CYC + 1);
    localparam logic [SetW-1:0] SettleLoad = SetW'(SETTLE_CYC);

    typedef enum logic [1:0] {StIdle, StSettle, StMeasure, StDone} state_e;

    state_e              state_q;
    logic                s1_q, s2_q, prev_q;
    logic                osc_edge;
    logic [WINDOW_W-1:0] win_q;
    logic [SetW-1:0]     set_q;
    logic [COUNT_W-1:0]  cnt_q, cnt_d;
    logic                ovf_q, ovf_d;
    logic                osc_en_q, busy_q, done_q, overflow_q;
    logic [COUNT_W-1:0]  result_q;

    // Free-running synchroniser plus delayed copy for rising-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            s1_q   <= osc_i;
            s2_q   <= s1_q;
            prev_q <= s2_q;
        end
    end

    assign osc_edge = s2_q & ~prev_q;

    // An edge arriving at all-ones holds the count and flags saturation
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (osc_edge) begin
            if (&cnt_q) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            win_q      <= '0;
            set_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            osc_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        win_q    <= window_i;
                        cnt_q    <= '0;
                        ovf_q    <= 1'b0;
                        set_q    <= SettleLoad;
                        osc_en_q <= 1'b1;
                        busy_q   <= 1'b1;
                        state_q  <= StSettle;
                    end
                end
                StSettle: begin
                    if (abort_i) begin
                        osc_en_q <= 1'b0;
                        busy_q   <= 1'b0;
                        state_q  <= StIdle;
                    end else if (set_q == SetW'(1)) begin
                        if (win_q == '0) begin
                            osc_en_q   <= 1'b0;
                            result_q   <= cnt_q;
                            overflow_q <= ovf_q;
                            done_q     <= 1'b1;
                            state_q    <= StDone;
                        end else begin
                            state_q <= StMeasure;
                        end
                    end else begin
                        set_q <= set_q - 1'b1;
                    end
                end
                StMeasure: begin
                    if (abort_i) begin
                        osc_en_q <= 1'b0;
                        busy_q   <= 1'b0;
                        state_q  <= StIdle;
                    end else begin
                        cnt_q <= cnt_d;
                        ovf_q <= ovf_d;
                        // Final window cycle: publish the count including this cycle's edge
                        if (win_q == WINDOW_W'(1)) begin
                            osc_en_q   <= 1'b0;
                            result_q   <= cnt_d;
                            overflow_q <= ovf_d;
                            done_q     <= 1'b1;
                            state_q    <= StDone;
                        end else begin
                            win_q <= win_q - 1'b1;
                        end
                    end
                end
                StDone: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    osc_en_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= StIdle;
                end
            endcase
        end
    end

    assign osc_en_o   = osc_en_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign result_o   = result_q;
    assign overflow_o = overflow_q;

endmodule
